// File: rtl/fp_pkg.sv
// Shared definitions for arbiters that front multi-cycle FP units.
// Holds the sequencer state encoding and common IEEE-754 single-precision constants.
package fp_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    localparam logic [31:0] FP_QNAN = 32'h7FC0_0000;
    localparam logic [31:0] FP_ONE  = 32'h3F80_0000;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first asserted request at or above ptr, wrapping modulo N.
// Reusable in front of any shared FP unit.
module rr_arbiter #(
    parameter int N  = 2,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] grant_id,
    output logic          grant_valid
);

    // Scan from ptr upward; the first hit wins and later hits are masked.
    always_comb begin : pick
        logic [IW:0]   sum_v;
        logic [IW-1:0] idx_v;
        grant       = '0;
        grant_id    = '0;
        grant_valid = 1'b0;
        sum_v       = '0;
        idx_v       = '0;
        for (int k = 0; k < N; k++) begin
            sum_v = {1'b0, ptr} + (IW+1)'(k);
            if (sum_v >= (IW+1)'(N)) begin
                sum_v = sum_v - (IW+1)'(N);
            end else begin
                sum_v = sum_v;
            end
            idx_v = sum_v[IW-1:0];
            if (!grant_valid && req[idx_v]) begin
                grant[idx_v] = 1'b1;
                grant_id     = idx_v;
                grant_valid  = 1'b1;
            end else begin
                grant_valid  = grant_valid;
            end
        end
    end

endmodule

// File: rtl/fp_recip_arbiter.sv
// Round-robin sharing of one multi-cycle FP reciprocal unit with a WAIT watchdog.
// Optional one-entry result cache enabled by defining RECIP_CACHE_EN.
module fp_recip_arbiter
    import fp_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int TIMEOUT = 31,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NUM_REQ-1:0]    req_valid,
    output logic [NUM_REQ-1:0]    req_ready,
    input  logic [32*NUM_REQ-1:0] req_operand,
    output logic [NUM_REQ-1:0]    resp_valid,
    input  logic [NUM_REQ-1:0]    resp_ready,
    output logic [31:0]           resp_data,
    output logic                  resp_err,
    output logic                  unit_start,
    output logic [31:0]           unit_operand,
    input  logic [31:0]           unit_result,
    input  logic                  unit_done,
    output logic                  busy
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    state_t               state_r, state_nxt_s;
    logic [ID_W-1:0]      rr_ptr_r, id_r, gnt_id_s;
    logic [NUM_REQ-1:0]   gnt_s;
    logic                 gnt_valid_s;
    logic [31:0]          op_r, res_r, op_sel_s;
    logic                 err_r;
    logic [CNT_W-1:0]     wait_cnt_r;
    logic                 accept_s, timeout_s, cache_hit_s;

    rr_arbiter #(.N(NUM_REQ), .IW(ID_W)) u_rr (
        .req         (req_valid),
        .ptr         (rr_ptr_r),
        .grant       (gnt_s),
        .grant_id    (gnt_id_s),
        .grant_valid (gnt_valid_s)
    );

    // Select the granted requester's operand.
    always_comb begin
        op_sel_s = 32'h0000_0000;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (gnt_id_s == ID_W'(i)) begin
                op_sel_s = req_operand[i*32 +: 32];
            end else begin
                op_sel_s = op_sel_s;
            end
        end
    end

    assign accept_s  = (state_r == IDLE) && gnt_valid_s;
    assign timeout_s = (wait_cnt_r == CNT_W'(TIMEOUT));

`ifdef RECIP_CACHE_EN
    logic        cache_v_r;
    logic [31:0] cache_op_r, cache_res_r;

    assign cache_hit_s = cache_v_r && (op_sel_s == cache_op_r);

    // Cache fills on clean completions only; a timeout invalidates it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cache_v_r   <= 1'b0;
            cache_op_r  <= 32'h0000_0000;
            cache_res_r <= 32'h0000_0000;
        end else if (state_r == WAIT && unit_done) begin
            cache_v_r   <= 1'b1;
            cache_op_r  <= op_r;
            cache_res_r <= unit_result;
        end else if (state_r == WAIT && timeout_s) begin
            cache_v_r   <= 1'b0;
        end else begin
            cache_v_r   <= cache_v_r;
        end
    end
`else
    assign cache_hit_s = 1'b0;
`endif

    // Next-state logic; done on the timeout cycle still counts as a clean completion.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (accept_s) begin
                    state_nxt_s = cache_hit_s ? RESP : ISSUE;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            ISSUE: state_nxt_s = WAIT;
            WAIT: begin
                if (unit_done || timeout_s) begin
                    state_nxt_s = RESP;
                end else begin
                    state_nxt_s = WAIT;
                end
            end
            RESP: begin
                if (resp_ready[id_r]) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = RESP;
                end
            end
            default: state_nxt_s = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Operand/grant capture, watchdog counter and result/error capture.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rr_ptr_r   <= '0;
            id_r       <= '0;
            op_r       <= 32'h0000_0000;
            res_r      <= 32'h0000_0000;
            err_r      <= 1'b0;
            wait_cnt_r <= '0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (accept_s) begin
                        op_r     <= op_sel_s;
                        id_r     <= gnt_id_s;
                        rr_ptr_r <= (gnt_id_s == ID_W'(NUM_REQ - 1)) ? '0 : gnt_id_s + ID_W'(1);
`ifdef RECIP_CACHE_EN
                        if (cache_hit_s) begin
                            res_r <= cache_res_r;
                            err_r <= 1'b0;
                        end else begin
                            res_r <= res_r;
                        end
`endif
                    end else begin
                        op_r <= op_r;
                    end
                end
                ISSUE: wait_cnt_r <= '0;
                WAIT: begin
                    wait_cnt_r <= wait_cnt_r + CNT_W'(1);
                    if (unit_done) begin
                        res_r <= unit_result;
                        err_r <= 1'b0;
                    end else if (timeout_s) begin
                        res_r <= FP_QNAN;
                        err_r <= 1'b1;
                    end else begin
                        res_r <= res_r;
                    end
                end
                RESP:    res_r <= res_r;
                default: res_r <= res_r;
            endcase
        end
    end

    // Response strobe decoded from the captured requester index.
    always_comb begin
        resp_valid = '0;
        if (state_r == RESP) begin
            resp_valid[id_r] = 1'b1;
        end else begin
            resp_valid = '0;
        end
    end

    assign req_ready    = (accept_s && !reset) ? gnt_s : '0;
    assign resp_data    = (state_r == RESP) ? res_r : 32'h0000_0000;
    assign resp_err     = (state_r == RESP) ? err_r : 1'b0;
    assign unit_start   = (state_r == ISSUE);
    assign unit_operand = op_r;
    assign busy         = (state_r != IDLE);

endmodule

// File: tb/tb_fp_recip_arbiter.sv
// Directed bench for fp_recip_arbiter with a behavioural reciprocal unit of programmable latency.
module tb_fp_recip_arbiter;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [1:0]  req_valid = 2'b00;
    logic [1:0]  req_ready;
    logic [63:0] req_operand = 64'h0;
    logic [1:0]  resp_valid;
    logic [1:0]  resp_ready = 2'b00;
    logic [31:0] resp_data;
    logic        resp_err;
    logic        unit_start;
    logic [31:0] unit_operand;
    logic [31:0] unit_result = 32'h0;
    logic        unit_done = 1'b0;
    logic        busy;

    int n_vec = 0;
    int n_err = 0;
    int lat = 9;
    int cnt = 0;
    int start_cnt = 0;
    bit inject = 1'b0;

    fp_recip_arbiter #(.NUM_REQ(2), .TIMEOUT(31)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_operand(req_operand),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_data(resp_data), .resp_err(resp_err),
        .unit_start(unit_start), .unit_operand(unit_operand),
        .unit_result(unit_result), .unit_done(unit_done),
        .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check_vec(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] recip_of(input logic [31:0] b);
        case (b)
            32'h4000_0000: recip_of = 32'h3F00_0000;
            32'h4080_0000: recip_of = 32'h3E80_0000;
            32'h3F80_0000: recip_of = 32'h3F80_0000;
            default:       recip_of = 32'hDEAD_BEEF;
        endcase
    endfunction

    // Unit model: done is sampled 'lat' rising edges after the edge that samples start; lat=0 never finishes.
    always @(negedge clk) begin
        unit_done = 1'b0;
        if (reset) begin
            cnt = 0;
        end else begin
            if (inject) begin
                unit_done   = 1'b1;
                unit_result = 32'h3F00_0000;
                inject      = 1'b0;
            end
            if (cnt > 0) begin
                cnt--;
                if (cnt == 0) begin
                    unit_done   = 1'b1;
                    unit_result = recip_of(unit_operand);
                end
            end
            if (unit_start) begin
                start_cnt++;
                if (lat > 0) cnt = lat;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        req_valid = 2'b00;
        resp_ready = 2'b00;
        tick();
        tick();
        reset = 1'b0;
        #1;
    endtask

    // Issue one request; cyc counts cycles from the handshake cycle (=0) to resp_valid.
    task automatic do_req(input int id, input logic [31:0] op, output int cyc);
        int w;
        req_operand[id*32 +: 32] = op;
        req_valid[id] = 1'b1;
        #1;
        w = 0;
        while (req_ready[id] !== 1'b1 && w < 100) begin
            tick();
            w++;
        end
        check_vec("accept_bound", 32'(w < 100), 32'd1);
        tick();
        req_valid[id] = 1'b0;
        cyc = 1;
        while (resp_valid == 2'b00 && cyc < 200) begin
            tick();
            cyc++;
        end
    endtask

    task automatic consume(input int id);
        resp_ready[id] = 1'b1;
        tick();
        resp_ready[id] = 1'b0;
        #1;
    endtask

    initial begin
        int cyc, s0, w;
        bit stable, rdy_seen;
        logic [1:0]  v0;
        logic [31:0] d0;
        logic        e0;

        // Reset state, sampled while reset is held.
        #2;
        check_vec("rst_busy", 32'(busy), 32'd0);
        check_vec("rst_resp_valid", 32'(resp_valid), 32'd0);
        check_vec("rst_unit_start", 32'(unit_start), 32'd0);
        check_vec("rst_unit_operand", unit_operand, 32'h0);
        check_vec("rst_resp_data", resp_data, 32'h0);
        do_reset();

        // Single request, unit latency 9.
        lat = 9;
        s0 = start_cnt;
        do_req(0, 32'h4000_0000, cyc);
        check_vec("single_latency", 32'(cyc), 32'd11);
        check_vec("single_valid", 32'(resp_valid), 32'd1);
        check_vec("single_data", resp_data, 32'h3F00_0000);
        check_vec("single_err", 32'(resp_err), 32'd0);
        check_vec("single_starts", 32'(start_cnt - s0), 32'd1);
        check_vec("single_operand", unit_operand, 32'h4000_0000);
        consume(0);
        check_vec("single_idle", 32'(busy), 32'd0);

        // Contention: both continuously valid, four rounds alternate 0,1,0,1.
        do_reset();
        lat = 3;
        req_operand = {32'h3F80_0000, 32'h4080_0000};
        req_valid = 2'b11;
        resp_ready = 2'b11;
        #1;
        for (int r = 0; r < 4; r++) begin
            w = 0;
            while (req_ready == 2'b00 && w < 50) begin
                tick();
                w++;
            end
            check_vec("rr_grant", 32'(req_ready), (r % 2 == 0) ? 32'd1 : 32'd2);
            tick();
            w = 0;
            while (resp_valid == 2'b00 && w < 100) begin
                tick();
                w++;
            end
            check_vec("rr_resp_valid", 32'(resp_valid), (r % 2 == 0) ? 32'd1 : 32'd2);
            check_vec("rr_data", resp_data, (r % 2 == 0) ? 32'h3E80_0000 : 32'h3F80_0000);
            tick();
        end
        req_valid = 2'b00;
        resp_ready = 2'b00;
        tick();

        // Backpressure: ready only on the wrong bit for 20 cycles, requester 1 waiting.
        do_reset();
        lat = 3;
        req_operand[31:0] = 32'h4080_0000;
        req_valid = 2'b01;
        #1;
        tick();
        req_valid = 2'b10;
        req_operand[63:32] = 32'h3F80_0000;
        resp_ready = 2'b10;
        w = 0;
        while (resp_valid == 2'b00 && w < 100) begin
            tick();
            w++;
        end
        v0 = resp_valid;
        d0 = resp_data;
        e0 = resp_err;
        stable = 1'b1;
        rdy_seen = 1'b0;
        repeat (20) begin
            tick();
            if (resp_valid !== v0 || resp_data !== d0 || resp_err !== e0) stable = 1'b0;
            if (req_ready !== 2'b00) rdy_seen = 1'b1;
        end
        check_vec("bp_valid", 32'(v0), 32'd1);
        check_vec("bp_data", d0, 32'h3E80_0000);
        check_vec("bp_stable", 32'(stable), 32'd1);
        check_vec("bp_no_ready", 32'(rdy_seen), 32'd0);
        resp_ready = 2'b01;
        tick();
        resp_ready = 2'b00;
        check_vec("bp_released", 32'(resp_valid), 32'd0);
        check_vec("bp_next_grant", 32'(req_ready), 32'd2);
        tick();
        req_valid = 2'b00;
        w = 0;
        while (resp_valid == 2'b00 && w < 100) begin
            tick();
            w++;
        end
        check_vec("bp_second_valid", 32'(resp_valid), 32'd2);
        check_vec("bp_second_data", resp_data, 32'h3F80_0000);
        consume(1);

        // Timeout: unit never answers; a late done in RESP is ignored.
        lat = 0;
        do_req(0, 32'h4000_0000, cyc);
        check_vec("to_latency", 32'(cyc), 32'd34);
        check_vec("to_data", resp_data, 32'h7FC0_0000);
        check_vec("to_err", 32'(resp_err), 32'd1);
        repeat (5) tick();
        inject = 1'b1;
        tick();
        tick();
        check_vec("to_late_valid", 32'(resp_valid), 32'd1);
        check_vec("to_late_data", resp_data, 32'h7FC0_0000);
        check_vec("to_late_err", 32'(resp_err), 32'd1);
        consume(0);
        check_vec("to_idle", 32'(busy), 32'd0);

        // Done on the same cycle as the timeout wins.
        lat = 32;
        do_req(0, 32'h4080_0000, cyc);
        check_vec("tie_latency", 32'(cyc), 32'd34);
        check_vec("tie_data", resp_data, 32'h3E80_0000);
        check_vec("tie_err", 32'(resp_err), 32'd0);
        consume(0);

        // Reset in the third WAIT cycle, then normal service.
        lat = 9;
        req_operand[31:0] = 32'h4000_0000;
        req_valid = 2'b01;
        #1;
        tick();
        req_valid = 2'b10;
        tick();
        tick();
        tick();
        check_vec("mid_busy_before", 32'(busy), 32'd1);
        reset = 1'b1;
        #1;
        check_vec("mid_busy", 32'(busy), 32'd0);
        check_vec("mid_req_ready", 32'(req_ready), 32'd0);
        check_vec("mid_resp_valid", 32'(resp_valid), 32'd0);
        check_vec("mid_unit_operand", unit_operand, 32'h0);
        check_vec("mid_unit_start", 32'(unit_start), 32'd0);
        req_valid = 2'b00;
        tick();
        reset = 1'b0;
        #1;
        do_req(0, 32'h4000_0000, cyc);
        check_vec("mid_after_latency", 32'(cyc), 32'd11);
        check_vec("mid_after_data", resp_data, 32'h3F00_0000);
        consume(0);

        // Repeated operand: hits the cache when enabled, otherwise re-issues.
        do_reset();
        lat = 4;
        do_req(0, 32'h4000_0000, cyc);
        check_vec("rep_first_latency", 32'(cyc), 32'd6);
        consume(0);
        s0 = start_cnt;
        do_req(0, 32'h4000_0000, cyc);
`ifdef RECIP_CACHE_EN
        check_vec("cache_hit_latency", 32'(cyc), 32'd1);
        check_vec("cache_hit_starts", 32'(start_cnt - s0), 32'd0);
        check_vec("cache_hit_data", resp_data, 32'h3F00_0000);
        check_vec("cache_hit_err", 32'(resp_err), 32'd0);
        consume(0);
        lat = 0;
        do_req(0, 32'h4080_0000, cyc);
        check_vec("cache_to_err", 32'(resp_err), 32'd1);
        consume(0);
        lat = 4;
        s0 = start_cnt;
        do_req(0, 32'h4000_0000, cyc);
        check_vec("cache_inval_latency", 32'(cyc), 32'd6);
        check_vec("cache_inval_starts", 32'(start_cnt - s0), 32'd1);
        check_vec("cache_inval_data", resp_data, 32'h3F00_0000);
        consume(0);
`else
        check_vec("rep_second_latency", 32'(cyc), 32'd6);
        check_vec("rep_second_starts", 32'(start_cnt - s0), 32'd1);
        check_vec("rep_second_data", resp_data, 32'h3F00_0000);
        consume(0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
